// File: rtl/regfile_wr_demux.sv
// regfile_wr_demux: buffered write side of the register file.
// Optional bypass lookup enabled by REGFILE_WR_BYPASS_EN.
module regfile_wr_demux #(
  parameter  int DATA_W   = 64,
  parameter  int ADDR_W   = 5,
  parameter  int DEPTH    = 2,
  parameter  int ZERO_REG = 31,
  localparam int NREG     = 2**ADDR_W,
  localparam int PTR_W    = $clog2(DEPTH),
  localparam int CNT_W    = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              rf_busy,
  output logic [NREG-1:0]   wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic [CNT_W-1:0]  count,
  input  logic [ADDR_W-1:0] byp_addr,
  output logic              byp_hit,
  output logic [DATA_W-1:0] byp_data
);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push, pop;

  assign in_ready = (count_q != CNT_W'(DEPTH));
  assign push = in_valid & in_ready
              & (in_addr != ADDR_W'(ZERO_REG));
  assign pop  = (count_q != '0) & ~rf_busy;
  assign count = count_q;

  // Next pointers and occupancy from push/pop.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + PTR_W'(1);
    if (pop)  rptr_d = rptr_q + PTR_W'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage and pointer state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      if (push) begin
        addr_q[wptr_q] <= in_addr;
        data_q[wptr_q] <= in_data;
      end
    end
  end

  // Issue the head entry as a one-hot write.
  always_comb begin
    wr_en   = '0;
    wr_data = '0;
    if (pop) begin
      wr_en[addr_q[rptr_q]] = 1'b1;
      wr_data               = data_q[rptr_q];
    end
  end

`ifdef REGFILE_WR_BYPASS_EN
  logic [PTR_W-1:0] byp_idx;

  // Scan oldest to youngest so the youngest match wins.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    byp_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      byp_idx = rptr_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q)
          && (addr_q[byp_idx] == byp_addr)
          && (byp_addr != ADDR_W'(ZERO_REG))) begin
        byp_hit  = 1'b1;
        byp_data = data_q[byp_idx];
      end
    end
  end
`else
  logic unused_byp;
  assign unused_byp = ^byp_addr;

  // Bypass disabled: outputs tied off.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
  end
`endif

endmodule

// File: tb/tb_regfile_wr_demux.sv
// tb_regfile_wr_demux: queue model plus directed vectors
// for the register-file write demux.
module tb_regfile_wr_demux;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_addr = '0;
  logic [63:0] in_data = '0;
  logic        rf_busy = 1'b0;
  logic [31:0] wr_en;
  logic [63:0] wr_data;
  logic [1:0]  count;
  logic [4:0]  byp_addr = '0;
  logic        byp_hit;
  logic [63:0] byp_data;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [4:0]  a;
    logic [63:0] d;
  } ent_t;
  ent_t q[$];

  regfile_wr_demux dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data),
    .rf_busy(rf_busy), .wr_en(wr_en),
    .wr_data(wr_data), .count(count),
    .byp_addr(byp_addr), .byp_hit(byp_hit),
    .byp_data(byp_data)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Model: queue of pending writes, updated at each edge.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
    end else begin
      bit do_pop, do_push;
      do_pop  = (q.size() > 0) && !rf_busy;
      do_push = in_valid && (q.size() < DEPTH)
                && (in_addr != 5'd31);
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back({in_addr, in_data});
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    logic [31:0] e_en;
    logic [63:0] e_data, e_bd;
    logic        e_bh;
    e_en = '0;
    e_data = '0;
    e_bh = 1'b0;
    e_bd = '0;
    if (q.size() > 0 && !rf_busy) begin
      e_en[q[0].a] = 1'b1;
      e_data = q[0].d;
    end
`ifdef REGFILE_WR_BYPASS_EN
    foreach (q[i])
      if (q[i].a == byp_addr && byp_addr != 5'd31) begin
        e_bh = 1'b1;
        e_bd = q[i].d;
      end
`endif
    chk("m_wr_en", 64'(wr_en), 64'(e_en));
    chk("m_wr_data", wr_data, e_data);
    chk("m_count", 64'(count), 64'(q.size()));
    chk("m_in_ready", 64'(in_ready),
        64'(q.size() != DEPTH));
    chk("m_byp_hit", 64'(byp_hit), 64'(e_bh));
    chk("m_byp_data", byp_data, e_bd);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(logic [4:0] a, logic [63:0] d);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  logic [4:0]  va [8] = '{5'd1, 5'd2, 5'd31, 5'd2,
                          5'd0, 5'd30, 5'd9, 5'd9};
  logic        vb [8] = '{1'b0, 1'b1, 1'b0, 1'b0,
                          1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    // Reset held with a request present.
    in_valid = 1'b1;
    in_addr  = 5'd9;
    in_data  = 64'h55;
    tick();
    tick();
    chk("rst_wr_en", 64'(wr_en), 64'h0);
    chk("rst_count", 64'(count), 64'h0);
    chk("rst_wr_data", wr_data, 64'h0);
    in_valid = 1'b0;
    reset_n  = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'h1);

    // Single write, one cycle latency.
    push(5'd5, 64'hDEADBEEF_00000005);
    #1;
    chk("one_wr_en", 64'(wr_en), 64'h20);
    chk("one_wr_data", wr_data, 64'hDEADBEEF_00000005);
    chk("one_count", 64'(count), 64'h1);
    tick();
    chk("one_count0", 64'(count), 64'h0);
    chk("one_wr_en0", 64'(wr_en), 64'h0);

    // Backpressure fills the FIFO.
    rf_busy = 1'b1;
    push(5'd1, 64'h11);
    push(5'd2, 64'h22);
    #1;
    chk("bp_count", 64'(count), 64'h2);
    chk("bp_in_ready", 64'(in_ready), 64'h0);
    chk("bp_wr_en", 64'(wr_en), 64'h0);
    rf_busy = 1'b0;
    #1;
    chk("bp_wr_en1", 64'(wr_en), 64'h2);
    chk("bp_wr_data1", wr_data, 64'h11);
    tick();
    chk("bp_wr_en2", 64'(wr_en), 64'h4);
    chk("bp_in_ready1", 64'(in_ready), 64'h1);
    tick();
    chk("bp_count0", 64'(count), 64'h0);

    // Zero register request is consumed and dropped.
    in_valid = 1'b1;
    in_addr  = 5'd31;
    in_data  = 64'h1;
    #1;
    chk("z_in_ready", 64'(in_ready), 64'h1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("z_count", 64'(count), 64'h0);
    chk("z_wr_en", 64'(wr_en), 64'h0);
    tick();

    // Full with pop: request is held off that cycle.
    rf_busy = 1'b1;
    push(5'd10, 64'hA0);
    push(5'd11, 64'hB0);
    rf_busy  = 1'b0;
    in_valid = 1'b1;
    in_addr  = 5'd12;
    in_data  = 64'hC0;
    #1;
    chk("fp_in_ready", 64'(in_ready), 64'h0);
    tick();
    chk("fp_count", 64'(count), 64'h1);
    chk("fp_wr_en", 64'(wr_en), 64'h800);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("fp_count0", 64'(count), 64'h0);

    // Reset mid-operation discards pending writes.
    rf_busy = 1'b1;
    push(5'd3, 64'h33);
    push(5'd4, 64'h44);
    chk("mr_count2", 64'(count), 64'h2);
    reset_n = 1'b0;
    #1;
    chk("mr_count0", 64'(count), 64'h0);
    tick();
    reset_n = 1'b1;
    rf_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("mr_no_wr", 64'(wr_en), 64'h0);
      tick();
    end

    // Bypass lookup of the youngest pending write.
    rf_busy = 1'b1;
    push(5'd7, 64'hAAAA);
    push(5'd7, 64'hBBBB);
    byp_addr = 5'd7;
    #1;
`ifdef REGFILE_WR_BYPASS_EN
    chk("byp_hit7", 64'(byp_hit), 64'h1);
    chk("byp_data7", byp_data, 64'hBBBB);
`else
    chk("byp_hit_off", 64'(byp_hit), 64'h0);
    chk("byp_data_off", byp_data, 64'h0);
`endif
    byp_addr = 5'd31;
    #1;
    chk("byp_hit31", 64'(byp_hit), 64'h0);
    byp_addr = 5'd7;
    rf_busy  = 1'b0;
    tick();
    tick();

    // Mixed back-to-back traffic against the model.
    for (int i = 0; i < 8; i++) begin
      rf_busy  = vb[i];
      byp_addr = va[(i + 3) % 8];
      push(va[i], 64'(i) * 64'h0101_0101 + 64'h7);
    end
    rf_busy = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("end_count", 64'(count), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_wr_demux.md
Name: regfile_wr_demux

Overview:
- Write side of the 64-bit register file: the counterpart to the read-port selection muxes.
- Accepts write-back requests (destination index + 64-bit data) from the WB stage over a valid/ready handshake.
- Buffers them in a small FIFO and, one per cycle, demultiplexes the data onto the register file: one-hot write enable, shared data bus.
- Absorbs cycles where the register file cannot take a write (rf_busy).

Parameters:
- DATA_W, 64, data width of each register.
- ADDR_W, 5, register index width; decoded output has 2**ADDR_W enables.
- DEPTH, 2, pending-write FIFO entries; power of two, >= 2.
- ZERO_REG, 31, index hardwired to zero; writes to it are dropped.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  write request present.
- in_ready  output  1  request accepted when in_valid & in_ready at rising edge.
- in_addr  input  ADDR_W  destination register index.
- in_data  input  DATA_W  write data.
- rf_busy  input  1  register file cannot accept a write this cycle.
- wr_en  output  2**ADDR_W  one-hot write enable, at most one bit high.
- wr_data  output  DATA_W  data for the enabled register.
- count  output  $clog2(DEPTH)+1  entries pending.
- byp_addr  input  ADDR_W  bypass lookup index.
- byp_hit  output  1  pending write to byp_addr exists.
- byp_data  output  DATA_W  youngest pending data for byp_addr.

Behaviour:
- Reset (reset_n low, asynchronous):
  - FIFO emptied; read/write pointers = 0; count = 0.
  - in_ready = 1 once released; wr_en = 0; wr_data = 0; byp_hit = 0; byp_data = 0.
  - Any writes pending when reset asserts mid-operation are discarded, never issued.
- Occupancy states, derived from count: EMPTY (0), PARTIAL (1..DEPTH-1), FULL (DEPTH).
  - EMPTY -> PARTIAL on push without pop.
  - PARTIAL -> FULL on push without pop at DEPTH-1.
  - FULL -> PARTIAL on pop.
  - PARTIAL -> EMPTY on pop without push at count 1.
  - Push + pop together: count unchanged.
- in_ready = (count != DEPTH). It is registered-state-only and never depends on in_valid or rf_busy, so there is no combinational loop.
- Push: in_valid & in_ready & (in_addr != ZERO_REG) writes {in_addr, in_data} at the write pointer. Write pointer increments mod DEPTH.
- ZERO_REG request: handshake completes (consumed) but nothing is enqueued. Count is unchanged and no wr_en is ever produced for it.
- Issue, combinational from FIFO head: when count != 0 and rf_busy = 0:
  - wr_en = one-hot of head addr; wr_data = head data.
  - Pop at the rising edge; read pointer increments mod DEPTH.
  - Otherwise wr_en = 0 and wr_data = 0.
- Latency: a request accepted at edge N into an empty FIFO with rf_busy low drives wr_en in the cycle following edge N and is written at edge N+1.
- Throughput: 1 write/cycle sustained when rf_busy stays low.
- Ordering: strict FIFO. Two pending writes to the same register issue in acceptance order, so the last write wins in the register file.
- Full with pop in same cycle: in_ready is still 0 that cycle; no push.
- Pointer wrap-around is transparent; count is the authoritative full/empty indicator.

Optional Feature:
- Macro: REGFILE_WR_BYPASS_EN.
- Defined:
  - byp_hit = 1 if any valid FIFO entry has addr == byp_addr and byp_addr != ZERO_REG.
  - byp_data = data of the youngest matching entry.
  - Purely combinational from FIFO state and byp_addr; an entry issuing this cycle still counts as a hit.
- Undefined: byp_addr is ignored; byp_hit = 0 and byp_data = 0 constantly. Ports remain present so instantiations are unchanged.

Test Plan:
- Reset: hold reset_n=0 with in_valid=1 -> wr_en=0, count=0, wr_data=0. Release -> in_ready=1.
- Single write: push addr=5, data=64'hDEADBEEF_00000005 with rf_busy=0 -> next cycle wr_en=32'h0000_0020, wr_data=that value. count returns to 0 after the edge.
- Backpressure: rf_busy=1, push addr 1 then 2 -> count=2, in_ready=0, wr_en=0. Drop rf_busy -> wr_en bit1, then bit2 on consecutive cycles; in_ready returns to 1.
- Zero register: push addr=31, data=64'h1 -> handshake accepted, count stays 0, wr_en never nonzero.
- Reset mid-operation: rf_busy=1, FIFO full (addr 3, 4), pulse reset_n low -> count=0. After release with rf_busy=0, no wr_en for 3 or 4.
- Bypass (REGFILE_WR_BYPASS_EN): rf_busy=1, push addr 7 data A, then addr 7 data B; byp_addr=7 -> byp_hit=1, byp_data=B. byp_addr=31 -> byp_hit=0. Macro undefined -> byp_hit=0 always.
